if_fetch_queue: RTL and testbench

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/fq_pkg.sv | 20 ++
 rtl/fq_ring.sv | 63 ++++++
 rtl/if_fetch_queue.sv | 138 +++++++++++++
 tb/tb_if_fetch_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Optional perf counters in the top are enabled with FETCH_PERF_EN.
package fq_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] FQ_RESET_PC = 32'h0000_3000;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fq_state_e;

    typedef struct packed {
        logic [ILEN-1:0] ins;
        logic [XLEN-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fq_ring.sv
// Circular instruction buffer: push at tail, pop at head, flush on redirect.
// Holds no fetch control; head data is visible combinationally.
module fq_ring
    import fq_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  fq_entry_t     push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fq_entry_t     head_o,
    output logic [CW-1:0] count_o
);

    fq_entry_t     mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && (cnt_q != '0);
        // A full ring still accepts a push when the head leaves in the same cycle
        do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) tail_d = tail_q + 1'b1;
            if (do_pop)  head_d = head_q + 1'b1;
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[tail_q] <= push_data_i;
    end

    assign head_o  = mem_q[head_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch unit: issues in-order imem requests and buffers responses for decode.
// Define FETCH_PERF_EN to add starvation and redirect counters.
module if_fetch_queue
    import fq_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = FQ_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            ins_valid,
    output logic [ILEN-1:0] ins,
    output logic [XLEN-1:0] pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     fq_starve_cnt,
    output logic [31:0]     fq_redirect_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fq_state_e       state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic            push, pop, flush;
    fq_entry_t       push_data, head;
    logic [CW-1:0]   count;
    logic [CW:0]     occ;
    logic            gnt_fire, rv_ok;

    fq_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk_i       (clk),
        .rst_ni      (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .count_o     (count)
    );

    // Reserve queue space for every in-flight request so responses never overflow
    assign occ       = {1'b0, count} + {1'b0, out_q};
    assign imem_req  = rst && (state_q == FETCH) && !redirect
                     && (out_q < CW'(MAX_OUT)) && (occ < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc_q;
    assign gnt_fire  = imem_req && imem_gnt;
    assign rv_ok     = imem_rvalid && (out_q != '0);

    assign ins_valid = (count != '0);
    assign ins       = ins_valid ? head.ins : '0;
    assign pc        = ins_valid ? head.pc  : '0;
    assign push_data = '{ins: imem_rdata, pc: resp_pc_q};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        if (redirect) begin
            flush      = 1'b1;
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            out_d      = out_q + CW'(gnt_fire) - CW'(rv_ok);
            drop_d     = out_d;
            state_d    = (drop_d != '0) ? DRAIN : FETCH;
        end else begin
            unique case (state_q)
                FETCH: begin
                    pop  = ins_valid && !stall;
                    push = rv_ok;
                    if (rv_ok)    resp_pc_d  = resp_pc_q + 32'd4;
                    if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;
                    out_d = out_q + CW'(gnt_fire) - CW'(rv_ok);
                end
                DRAIN: begin
                    pop   = ins_valid && !stall;
                    out_d = out_q - CW'(rv_ok);
                    if (rv_ok && (drop_q != '0)) drop_d = drop_q - 1'b1;
                    if (drop_d == '0) state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] starve_q, redir_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
            redir_q  <= '0;
        end else begin
            if (!ins_valid && !stall && (starve_q != '1)) starve_q <= starve_q + 32'd1;
            if (redirect && (redir_q != '1))              redir_q  <= redir_q + 32'd1;
        end
    end

    assign fq_starve_cnt   = starve_q;
    assign fq_redirect_cnt = redir_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: vector table plus scoreboarded
// imem responder covering stall, redirect, drain, grant backpressure and reset.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst, redirect, stall, imem_gnt, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, ins_valid;
    logic [31:0] imem_addr, ins, pc;

    if_fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ins_valid   (ins_valid),
        .ins         (ins),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] pc;
    } vec_t;

    pend_t       pend[$];
    exp_t        expq[$];
    vec_t        tbl[6];
    int          checks, errors, epoch, ndeliv, dead_cnt, n0;
    bit          gnt_en, rv_en, spurious, want_first;
    logic [31:0] exp_first, next_addr;
    logic        s_req, s_iv;
    logic [31:0] s_addr, s_pc, s_ins;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h1357_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle, entered and left just after a falling edge
    task automatic cycle();
        pend_t p;
        exp_t  e;
        imem_gnt = gnt_en;
        if (spurious) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAD0_BAD0;
        end else if (rv_en && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = (dead_cnt > 0) ? 32'hDEAD_0000 + 32'(3 - dead_cnt)
                                         : data_of(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #2;
        s_req  = imem_req;
        s_addr = imem_addr;
        s_iv   = ins_valid;
        s_pc   = pc;
        s_ins  = ins;
        if (s_iv && !stall) begin
            ndeliv++;
            chk("no_dead", 32'(s_ins[31:16] == 16'hDEAD), 32'd0);
            if (expq.size() == 0) begin
                chk("deliver_unexpected", s_pc, 32'hFFFF_FFFF);
            end else begin
                e = expq.pop_front();
                chk("sb_pc", s_pc, e.pc);
                chk("sb_ins", s_ins, e.ins);
            end
            if (want_first) begin
                want_first = 1'b0;
                chk("first_pc", s_pc, exp_first);
            end
        end
        if (s_req && imem_gnt) begin
            chk("grant_addr", s_addr, next_addr);
            pend.push_back('{s_addr, epoch});
            next_addr = next_addr + 32'd4;
        end
        if (imem_rvalid && !spurious) begin
            p = pend.pop_front();
            if (p.epoch == epoch) expq.push_back('{p.addr, imem_rdata});
            if (dead_cnt > 0) dead_cnt--;
        end
        if (redirect) begin
            epoch++;
            expq.delete();
            next_addr = redirect_pc;
        end
        @(negedge clk);
    endtask

    task automatic apply_table();
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].req));
            chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_iv", i), 32'(s_iv), 32'(tbl[i].iv));
            chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
        end
    endtask

    // Assert reset in the middle of a low clock phase, release on a falling edge
    task automatic async_reset_mid();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_iv", 32'(ins_valid), 32'd0);
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_pc", pc, 32'd0);
        chk("arst_ins", ins, 32'd0);
        pend.delete();
        expq.delete();
        epoch++;
        next_addr = 32'h3000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        checks = 0; errors = 0; epoch = 0; ndeliv = 0; dead_cnt = 0;
        gnt_en = 1'b1; rv_en = 1'b1; spurious = 1'b0; want_first = 1'b0;
        exp_first = '0; next_addr = 32'h3000;
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

        tbl[0] = '{1'b1, 32'h3000, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'h3004, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 32'h3008, 1'b1, 32'h3000};
        tbl[3] = '{1'b1, 32'h300C, 1'b1, 32'h3004};
        tbl[4] = '{1'b1, 32'h3010, 1'b1, 32'h3008};
        tbl[5] = '{1'b1, 32'h3014, 1'b1, 32'h300C};

        @(negedge clk);
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_iv", 32'(ins_valid), 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_pc", pc, 32'd0);
        rst = 1'b1;
        apply_table();

        // Redirect with two responses in flight
        rv_en = 1'b0;
        cycle();
        cycle();
        redirect = 1'b1;
        redirect_pc = 32'h4000;
        cycle();
        chk("redir_req_low", 32'(s_req), 32'd0);
        redirect = 1'b0;
        rv_en = 1'b1;
        dead_cnt = 2;
        want_first = 1'b1;
        exp_first = 32'h4000;
        repeat (10) cycle();
        chk("first_seen_4000", 32'(want_first), 32'd0);

        // Second redirect while draining
        rv_en = 1'b0;
        cycle();
        cycle();
        redirect = 1'b1;
        redirect_pc = 32'h4100;
        cycle();
        redirect_pc = 32'h5000;
        cycle();
        chk("drain_redir_req_low", 32'(s_req), 32'd0);
        redirect = 1'b0;
        rv_en = 1'b1;
        want_first = 1'b1;
        exp_first = 32'h5000;
        repeat (12) cycle();
        chk("first_seen_5000", 32'(want_first), 32'd0);

        // Grant backpressure
        gnt_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("nognt_req", 32'(s_req), 32'd1);
            chk("nognt_addr", s_addr, next_addr);
        end
        gnt_en = 1'b1;
        n0 = ndeliv;
        repeat (8) cycle();
        chk("gnt_resume_flow", 32'(ndeliv - n0 >= 4), 32'd1);

        // Stall fill, illegal response, then drain
        async_reset_mid();
        stall = 1'b1;
        repeat (10) cycle();
        chk("full_req", 32'(s_req), 32'd0);
        chk("full_iv", 32'(s_iv), 32'd1);
        chk("full_pc", s_pc, 32'h3000);
        spurious = 1'b1;
        cycle();
        spurious = 1'b0;
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("unstall_iv", 32'(s_iv), 32'd1);
            chk("unstall_pc", s_pc, 32'h3000 + 32'(4 * k));
        end
        n0 = ndeliv;
        repeat (10) cycle();
        chk("stream_flow", 32'(ndeliv - n0 >= 8), 32'd1);

        // Reset mid-stream with three entries queued
        stall = 1'b1;
        repeat (2) cycle();
        stall = 1'b0;
        async_reset_mid();
        apply_table();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
